ddr3_status_uart: RTL and testbench

//  Downstream consumer of the DDR3 memory tester status (running/state/fail_high/fail_low).

---
 rtl/ddr3_status_uart.sv | 191 +++++++++++++++++++
 tb/tb_ddr3_status_uart.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_status_uart.sv
// Snapshots DDR3 tester status on completion and sends a 9-byte ASCII report over 8N1 UART.
// Optional heartbeat reports while running: define STATUS_HEARTBEAT_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line high, waiting for a trigger
// S_START | start bit (tx=0) for DIV cycles
// S_DATA  | 8 data bits, LSB first, DIV cycles each
// S_STOP  | stop bit (tx=1); after byte 9 the report completes here
module ddr3_status_uart #(
    parameter int CLK_HZ           = 27_000_000,
    parameter int BAUD             = 115_200,
    parameter int HEARTBEAT_CYCLES = 27_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       running,
    input  logic [3:0] state,
    input  logic       fail_high,
    input  logic       fail_low,
    output logic       tx,
    output logic       busy,
    output logic [7:0] msg_count
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [3:0]    LAST_BYTE = 4'd8;

    if (DIV < 2 || HEARTBEAT_CYCLES < 2) begin : g_cfg_check
        $error("ddr3_status_uart: CLK_HZ/BAUD must be >= 2 and HEARTBEAT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    uart_state_t   fsm_q;
    logic          running_d;
    logic          trig_q;
    logic          pending;
    logic [3:0]    snap_state, cur_state;
    logic          snap_fh, snap_fl, cur_fh, cur_fl;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [3:0]    byte_idx;
    logic [7:0]    shift;
    logic          bit_end;
    logic          hb_fire;
    logic          trig_src;

`ifdef STATUS_HEARTBEAT_EN
    localparam int HW = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [HW-1:0] HB_LAST = HW'(HEARTBEAT_CYCLES - 1);

    logic [HW-1:0] hb_cnt;

    always_ff @(posedge clk) begin
        if (reset || !running) begin
            hb_cnt <= '0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    assign hb_fire = running && (hb_cnt == HB_LAST);
`else
    assign hb_fire = 1'b0;
`endif

    assign trig_src = (running_d && !running) || hb_fire;
    assign bit_end  = (baud_cnt == BAUD_LAST);

    function automatic logic [7:0] report_byte(input logic [3:0] idx, input logic [3:0] st,
                                               input logic fh, input logic fl);
        logic [7:0] b;
        case (idx)
            4'd0, 4'd1: b = 8'h44;
            4'd2:       b = 8'h52;
            4'd3:       b = 8'h20;
            4'd4:       b = fh ? 8'h48 : 8'h2D;
            4'd5:       b = fl ? 8'h4C : 8'h2D;
            4'd6:       b = (st < 4'd10) ? (8'h30 + {4'h0, st}) : (8'h37 + {4'h0, st});
            4'd7:       b = 8'h0D;
            default:    b = 8'h0A;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q      <= S_IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            msg_count  <= 8'd0;
            pending    <= 1'b0;
            running_d  <= 1'b0;
            trig_q     <= 1'b0;
            snap_state <= 4'd0;
            snap_fh    <= 1'b0;
            snap_fl    <= 1'b0;
            cur_state  <= 4'd0;
            cur_fh     <= 1'b0;
            cur_fl     <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 4'd0;
            shift      <= 8'd0;
        end else begin
            running_d <= running;
            trig_q    <= trig_src;
            // snap holds the next report's status; the report in flight reads cur_* only
            if (trig_src) begin
                snap_state <= state;
                snap_fh    <= fail_high;
                snap_fl    <= fail_low;
            end
            if (trig_q && busy) begin
                pending <= 1'b1;
            end
            if (fsm_q != S_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end

            case (fsm_q)
                S_IDLE: begin
                    if (trig_q) begin
                        fsm_q     <= S_START;
                        busy      <= 1'b1;
                        tx        <= 1'b0;
                        baud_cnt  <= '0;
                        byte_idx  <= 4'd0;
                        shift     <= report_byte(4'd0, snap_state, snap_fh, snap_fl);
                        cur_state <= snap_state;
                        cur_fh    <= snap_fh;
                        cur_fl    <= snap_fl;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        fsm_q   <= S_DATA;
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            fsm_q <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (byte_idx == LAST_BYTE) begin
                            msg_count <= msg_count + 8'd1;
                            // a trigger landing on this edge counts as pending
                            if (pending || trig_q) begin
                                pending   <= 1'b0;
                                fsm_q     <= S_START;
                                tx        <= 1'b0;
                                byte_idx  <= 4'd0;
                                shift     <= report_byte(4'd0, snap_state, snap_fh, snap_fl);
                                cur_state <= snap_state;
                                cur_fh    <= snap_fh;
                                cur_fl    <= snap_fl;
                            end else begin
                                fsm_q <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            fsm_q    <= S_START;
                            tx       <= 1'b0;
                            byte_idx <= byte_idx + 4'd1;
                            shift    <= report_byte(byte_idx + 4'd1, cur_state, cur_fh, cur_fl);
                        end
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_status_uart.sv
// Randomized bench for ddr3_status_uart: independent UART decoder plus a text-level report model.
module tb_ddr3_status_uart;

    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;
    localparam int RPT   = 9 * FRAME;
`ifdef STATUS_HEARTBEAT_EN
    localparam int HB_REPORTS = 2;
    localparam int HB_FIRST   = 2001;
`else
    localparam int HB_REPORTS = 0;
    localparam int HB_FIRST   = -1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       running = 1'b0;
    logic [3:0] state = 4'd0;
    logic       fail_high = 1'b0;
    logic       fail_low = 1'b0;
    logic       tx;
    logic       busy;
    logic [7:0] msg_count;

    int vectors = 0;
    int miscompares = 0;
    int exp_msgs = 0;

    logic [7:0] rx_q[$];
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'd0;

    typedef struct {
        int         at;
        logic [3:0] st;
        logic       fh;
        logic       fl;
    } ev_t;
    ev_t ev_q[$];

    ddr3_status_uart #(
        .CLK_HZ(16),
        .BAUD(1),
        .HEARTBEAT_CYCLES(2000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .running(running),
        .state(state),
        .fail_high(fail_high),
        .fail_low(fail_low),
        .tx(tx),
        .busy(busy),
        .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string report_text(input logic [3:0] st, input logic fh, input logic fl);
        string hexd;
        hexd = "0123456789ABCDEF";
        return $sformatf("DDR %c%c%c%c%c", fh ? "H" : "-", fl ? "L" : "-", hexd[st], 8'h0D, 8'h0A);
    endfunction

    // mid-bit sampling UART receiver, independent of the DUT's internals
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == DIV / 2) chk("start_bit", 32'(tx), 32'd0);
                if (rx_cnt > DIV && rx_cnt < 9 * DIV && (rx_cnt % DIV) == DIV / 2)
                    rx_byte[rx_cnt / DIV - 1] = tx;
                if (rx_cnt == 9 * DIV + DIV / 2) begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    rx_q.push_back(rx_byte);
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic add_ev(input int at, input logic [3:0] st, input logic fh, input logic fl);
        ev_t e;
        e.at = at;
        e.st = st;
        e.fh = fh;
        e.fl = fl;
        ev_q.push_back(e);
    endtask

    task automatic scramble();
        state     = 4'($urandom_range(15, 0));
        fail_high = 1'($urandom_range(1, 0));
        fail_low  = 1'($urandom_range(1, 0));
    endtask

    // falling edge of running; returns at the negedge after the first busy edge
    task automatic fire(input string tag, input logic [3:0] st, input logic fh, input logic fl);
        @(negedge clk);
        running = 1'b1;
        state = st;
        fail_high = fh;
        fail_low = fl;
        repeat (3) @(negedge clk);
        running = 1'b0;
        @(negedge clk);
        chk({tag, ":tx_before_start"}, 32'(tx), 32'd1);
        chk({tag, ":busy_before_start"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, ":tx_start"}, 32'(tx), 32'd0);
        chk({tag, ":busy_start"}, 32'(busy), 32'd1);
        scramble();
    endtask

    task automatic run_report(input string tag, input logic [3:0] st, input logic fh, input logic fl);
        int    len;
        int    scramble_at;
        bit    had_ev;
        ev_t   last_ev;
        string exp_s;
        logic [7:0] got_b;

        had_ev = (ev_q.size() > 0);
        if (had_ev) last_ev = ev_q[ev_q.size() - 1];
        exp_s = report_text(st, fh, fl);
        if (had_ev) exp_s = {exp_s, report_text(last_ev.st, last_ev.fh, last_ev.fl)};
        rx_q.delete();
        scramble_at = -1;

        fire(tag, st, fh, fl);
        len = 1;
        while (len < 4000) begin
            @(negedge clk);
            if (!busy) break;
            len++;
            if (ev_q.size() > 0) begin
                if (len == ev_q[0].at - 2) begin
                    running = 1'b1;
                    state = ev_q[0].st;
                    fail_high = ev_q[0].fh;
                    fail_low = ev_q[0].fl;
                end else if (len == ev_q[0].at) begin
                    running = 1'b0;
                    void'(ev_q.pop_front());
                    scramble_at = len + 2;
                end
            end
            if (len == scramble_at) scramble();
        end
        ev_q.delete();

        chk({tag, ":busy_len"}, 32'(len), 32'(had_ev ? 2 * RPT : RPT));
        chk({tag, ":byte_count"}, 32'(rx_q.size()), 32'(exp_s.len()));
        for (int i = 0; i < exp_s.len(); i++) begin
            got_b = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            chk($sformatf("%s:byte%0d", tag, i), 32'(got_b), 32'(exp_s[i]));
        end
        exp_msgs += had_ev ? 2 : 1;
        chk({tag, ":msg_count"}, 32'(msg_count), 32'(exp_msgs % 256));
    endtask

    task automatic run_reset();
        fire("rst", 4'($urandom_range(15, 0)), 1'b1, 1'b0);
        repeat (199) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst:tx", 32'(tx), 32'd1);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:msg_count", 32'(msg_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_msgs = 0;
        repeat (12 * DIV) @(negedge clk);
        chk("rst:idle_tx", 32'(tx), 32'd1);
        chk("rst:idle_busy", 32'(busy), 32'd0);
        rx_q.delete();
    endtask

    task automatic run_heartbeat();
        int   first_low;
        int   rises;
        int   w;
        logic prev_busy;
        first_low = -1;
        rises = 0;
        prev_busy = 1'b0;
        @(negedge clk);
        running = 1'b1;
        scramble();
        for (int k = 1; k <= 4500; k++) begin
            @(negedge clk);
            if (tx === 1'b0 && first_low < 0) first_low = k;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        chk("hb:reports", 32'(rises), 32'(HB_REPORTS));
        chk("hb:first_start", 32'(first_low), 32'(HB_FIRST));
        running = 1'b0;
        repeat (4) @(negedge clk);
        w = 0;
        while (busy && w < 6000) begin
            @(negedge clk);
            w++;
        end
        chk("hb:drain_busy", 32'(busy), 32'd0);
        exp_msgs += HB_REPORTS + 1;
        chk("hb:msg_count", 32'(msg_count), 32'(exp_msgs % 256));
        rx_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset:tx", 32'(tx), 32'd1);
            chk("reset:busy", 32'(busy), 32'd0);
            chk("reset:msg_count", 32'(msg_count), 32'd0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle:tx", 32'(tx), 32'd1);
        chk("idle:busy", 32'(busy), 32'd0);

        run_report("basic", 4'd9, 1'b0, 1'b0);
        run_report("fail_both", 4'd9, 1'b1, 1'b1);
        run_report("fail_low", 4'hA, 1'b0, 1'b1);

        add_ev(300, 4'd6, 1'b0, 1'b0);
        run_report("pending", 4'($urandom_range(15, 0)), 1'b1, 1'b0);

        add_ev(300, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        add_ev(700, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        run_report("refresh", 4'($urandom_range(15, 0)), 1'b0, 1'b1);

        add_ev(RPT - 1, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        run_report("same_edge", 4'($urandom_range(15, 0)), 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            run_report($sformatf("rand%0d", i), 4'($urandom_range(15, 0)),
                       1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        run_reset();
        run_report("after_reset", 4'($urandom_range(15, 0)),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));

        run_heartbeat();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
